// File: rtl/display_scroll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_scroll_ctrl_pkg
// Shared definitions for the display scroll controller: the scroll FSM state
// encoding, display geometry constants and the digit-count to window-offset
// helper.
// -----------------------------------------------------------------------------
package display_scroll_ctrl_pkg;

    localparam int DIGITS  = 11;  // BCD digits in a result
    localparam int WINDOW  = 6;   // digits visible on the display
    localparam int MAX_POS = 5;   // DIGITS - WINDOW, largest window offset
    localparam int BCD_W   = 44;  // DIGITS * 4

    typedef enum logic [2:0] {
        IDLE,
        HOLD_LOW,
        STEP_UP,
        HOLD_HIGH,
        STEP_DOWN
    } scroll_state_e;

    // Furthest window offset needed to show every significant digit.
    function automatic logic [2:0] max_pos_from_nd(input logic [3:0] nd);
        if (nd > 4'(WINDOW)) begin
            return 3'(nd - 4'(WINDOW));
        end
        return 3'd0;
    endfunction

endpackage

// File: rtl/display_scroll_ctrl_bcd_digit_count.sv
// -----------------------------------------------------------------------------
// bcd_digit_count
// Combinational priority encoder: returns the number of significant digits of
// an 11-digit BCD value (index of the highest nonzero nibble + 1). An all-zero
// value still counts as one digit so that a single "0" is displayed.
//
// Ports:
//   bcd_i : 44-bit BCD value, digit 0 in [3:0]
//   nd_o  : significant digit count, 1..11
// -----------------------------------------------------------------------------
module bcd_digit_count
    import display_scroll_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [3:0]       nd_o
);

    // Scanning upward lets the highest nonzero nibble win.
    always_comb begin
        nd_o = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_i[4*i +: 4] != 4'd0) begin
                nd_o = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/display_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// display_scroll_ctrl
// Latches an 11-digit BCD result and, when it has more than six significant
// digits, ping-pongs the 6-digit display window across it one digit per step
// period, dwelling DWELL_STEPS step periods at each end.
//
// Ports:
//   clk         : system clock
//   reset       : synchronous active-high reset
//   load        : single-cycle strobe capturing BCD_In
//   BCD_In      : 44-bit BCD result to display
//   BCD_Latched : registered copy of the last loaded value
//   count       : window select, 0..5
//   scrolling   : latched value has more than six significant digits
// -----------------------------------------------------------------------------
module display_scroll_ctrl
    import display_scroll_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 25_000_000,
    parameter int DWELL_STEPS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] BCD_In,
    output logic [BCD_W-1:0] BCD_Latched,
    output logic [2:0]       count,
    output logic             scrolling
);

    localparam int PW = $clog2(STEP_CYCLES);
    localparam int DW = $clog2(DWELL_STEPS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_STEPS - 1);

    scroll_state_e    state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       max_pos_q, max_pos_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;

    logic [3:0] nd_in;
    logic [2:0] max_pos_in;
    logic       step;

    bcd_digit_count u_digit_count (
        .bcd_i (BCD_In),
        .nd_o  (nd_in)
    );

    assign max_pos_in = max_pos_from_nd(nd_in);
    assign step       = (presc_q == PRESC_LAST);

    always_comb begin
        state_d   = state_q;
        presc_d   = step ? '0 : presc_q + 1'b1;
        dwell_d   = dwell_q;
        count_d   = count_q;
        max_pos_d = max_pos_q;
        bcd_d     = bcd_q;

        if (load) begin
            // A load always restarts the pattern from the low end.
            bcd_d     = BCD_In;
            max_pos_d = max_pos_in;
            presc_d   = '0;
            dwell_d   = '0;
            count_d   = 3'd0;
            state_d   = (max_pos_in != 3'd0) ? HOLD_LOW : IDLE;
        end else if (step) begin
            unique case (state_q)
                IDLE: begin
                end
                HOLD_LOW: begin
                    if (dwell_q == DWELL_LAST) begin
                        state_d = STEP_UP;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                STEP_UP: begin
                    count_d = count_q + 3'd1;
                    if (count_q + 3'd1 == max_pos_q) begin
                        state_d = HOLD_HIGH;
                        dwell_d = '0;
                    end
                end
                HOLD_HIGH: begin
                    if (dwell_q == DWELL_LAST) begin
                        state_d = STEP_DOWN;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                STEP_DOWN: begin
                    count_d = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state_d = HOLD_LOW;
                        dwell_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            dwell_q   <= '0;
            count_q   <= 3'd0;
            max_pos_q <= 3'd0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dwell_q   <= dwell_d;
            count_q   <= count_d;
            max_pos_q <= max_pos_d;
            bcd_q     <= bcd_d;
        end
    end

    assign BCD_Latched = bcd_q;
    assign count       = count_q;
    assign scrolling   = (max_pos_q != 3'd0);

endmodule
